mem_access_ctrl: RTL

- Sequences the shared byte-addressed 128-byte memory (word write port, combinational 4-byte little-endian read at any byte address).
- Arbitrates between the instruction-fetch requester (word reads only) and the load/store requester (byte/half/word, signed/unsigned loads).
- Sub-word stores are done as aligned read-modify-write, because the memory only writes 4 bytes at a time.
- Checks alignment and address range, and returns one registered response per accepted request.

---
 rtl/mem_access_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: arbitrates fetch and load/store ports onto a 128-byte word-write memory, with sub-word store read-modify-write.
// Define MEM_ACCESS_RR_EN for round-robin arbitration; otherwise the data port has fixed priority.
module mem_access_ctrl #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req_valid,
  output logic        i_req_ready,
  input  logic [31:0] i_addr,
  output logic        i_rsp_valid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req_valid,
  output logic        d_req_ready,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic        d_unsigned,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_we,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;
  state_t state;
  logic owner;
  logic we_r, uns_r, err_r;
  logic [1:0] size_r;
  logic [31:0] addr_r, wdata_r, merge;
  logic d_win, i_win, d_err_n, i_err_n, sub_store;
  logic [4:0] shamt;
  logic [31:0] aligned, shifted, load_val, lane_mask, merged, rsp_data;
`ifdef MEM_ACCESS_RR_EN
  logic last_grant;
  assign d_win = d_req_valid & (~i_req_valid | last_grant);
`else
  assign d_win = d_req_valid;
`endif
  assign i_win = i_req_valid & ~d_win;
  assign d_req_ready = (state == IDLE) & d_win;
  assign i_req_ready = (state == IDLE) & i_win;
  assign d_err_n = (d_size == 2'b11) | ((d_size == 2'b01) & d_addr[0]) | ((d_size == 2'b10) & |d_addr[1:0])
                 | (({d_addr[31:2], 2'b00} + 32'd3) >= 32'(MEM_BYTES));
  assign i_err_n = |i_addr[1:0] | (({i_addr[31:2], 2'b00} + 32'd3) >= 32'(MEM_BYTES));
  assign aligned = {addr_r[31:2], 2'b00};
  assign shamt = {addr_r[1:0], 3'b000};
  assign shifted = mem_data_out >> shamt;
  assign load_val = size_r == 2'b00 ? {{24{~uns_r & shifted[7]}}, shifted[7:0]}
                  : size_r == 2'b01 ? {{16{~uns_r & shifted[15]}}, shifted[15:0]} : shifted;
  assign lane_mask = (size_r == 2'b00 ? 32'h0000_00ff : 32'h0000_ffff) << shamt;
  assign merged = (merge & ~lane_mask) | ((wdata_r << shamt) & lane_mask);
  assign sub_store = we_r & (size_r != 2'b10) & ~err_r;
  assign rsp_data = (err_r | we_r) ? 32'd0 : load_val;
  assign mem_we = ((state == ACCESS) & we_r & (size_r == 2'b10) & ~err_r) | (state == WRITE);
  assign mem_address = (state == ACCESS || state == WRITE) ? aligned : 32'd0;
  assign mem_data_in = state == WRITE ? merged : mem_we ? wdata_r : 32'd0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      owner <= 1'b0;
      we_r <= 1'b0;
      uns_r <= 1'b0;
      err_r <= 1'b0;
      size_r <= 2'b00;
      addr_r <= '0;
      wdata_r <= '0;
      merge <= '0;
      i_rsp_valid <= 1'b0;
      i_rdata <= '0;
      i_err <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rdata <= '0;
      d_err <= 1'b0;
`ifdef MEM_ACCESS_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (d_win | i_win) begin
          owner <= i_win;
          we_r <= i_win ? 1'b0 : d_we;
          size_r <= i_win ? 2'b10 : d_size;
          uns_r <= i_win ? 1'b0 : d_unsigned;
          addr_r <= i_win ? i_addr : d_addr;
          wdata_r <= i_win ? 32'd0 : d_wdata;
          err_r <= i_win ? i_err_n : d_err_n;
`ifdef MEM_ACCESS_RR_EN
          last_grant <= i_win;
`endif
          state <= ACCESS;
        end
        ACCESS: if (sub_store) begin
          merge <= mem_data_out;
          state <= WRITE;
        end else begin
          state <= RESP;
          if (owner) begin
            i_rsp_valid <= 1'b1;
            i_rdata <= rsp_data;
            i_err <= err_r;
          end else begin
            d_rsp_valid <= 1'b1;
            d_rdata <= rsp_data;
            d_err <= err_r;
          end
        end
        WRITE: begin
          d_rsp_valid <= 1'b1;
          d_rdata <= '0;
          d_err <= 1'b0;
          state <= RESP;
        end
        default: begin
          i_rsp_valid <= 1'b0;
          d_rsp_valid <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
